// File: rtl/seven_segment_mux.sv
// Eight-digit common-anode seven-segment scanner: time-multiplexes a 32-bit hex
// value with per-digit decimal points and blanking, frame-latched to avoid tearing.
module seven_segment_mux #(
    parameter int CLK_FREQUENCY          = 100_000_000,
    parameter int MIN_SEGMENT_DISPLAY_US = 10_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        display_en,
    input  logic [31:0] display_val,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank,
    output logic [6:0]  segments,
    output logic        dp,
    output logic [7:0]  anode,
    output logic        frame_done
);

    localparam int SEGMENT_CLOCKS = CLK_FREQUENCY / 1_000_000 * MIN_SEGMENT_DISPLAY_US;
    localparam int TIMER_W        = (SEGMENT_CLOCKS < 2) ? 1 : $clog2(SEGMENT_CLOCKS);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SEGMENT_CLOCKS - 1);

    generate
        if (SEGMENT_CLOCKS < 2) begin : g_bad_timing
            $error("seven_segment_mux: SEGMENT_CLOCKS must be at least 2");
        end
    endgenerate

    typedef enum logic {OFF, RUN} state_t;

    state_t              state_reg;
    logic [TIMER_W-1:0]  timer_reg;
    logic [2:0]          index_reg;
    logic [31:0]         shadow_val_reg;
    logic [7:0]          shadow_dp_reg;
    logic [7:0]          shadow_blank_reg;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // A shadow load happens on the OFF->RUN edge and on every frame wrap; the
    // digit shown on that edge must come straight from the inputs being latched.
    logic        timer_last;
    logic        frame_wrap;
    logic        load;
    logic [2:0]  sel_index;
    logic [31:0] src_val;
    logic [7:0]  src_dp;
    logic [7:0]  src_blank;

    assign timer_last = (timer_reg == TIMER_LAST);
    assign frame_wrap = (state_reg == RUN) && timer_last && (index_reg == 3'd7);
    assign load       = display_en && ((state_reg == OFF) || frame_wrap);
    assign sel_index  = (state_reg == RUN) ? index_reg + 3'd1 : 3'd0;
    assign src_val    = load ? display_val : shadow_val_reg;
    assign src_dp     = load ? dp_in       : shadow_dp_reg;
    assign src_blank  = load ? blank       : shadow_blank_reg;

    logic [6:0] digit_seg [8];
    logic       digit_dp  [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign digit_seg[gi] = src_blank[gi] ? 7'h7F : decode(src_val[4*gi +: 4]);
            assign digit_dp[gi]  = src_blank[gi] ? 1'b1  : ~src_dp[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= OFF;
            timer_reg        <= '0;
            index_reg        <= '0;
            shadow_val_reg   <= '0;
            shadow_dp_reg    <= '0;
            shadow_blank_reg <= '0;
            anode            <= 8'hFF;
            segments         <= 7'h7F;
            dp               <= 1'b1;
            frame_done       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_reg)
                OFF: begin
                    timer_reg <= '0;
                    index_reg <= '0;
                    if (display_en) begin
                        state_reg        <= RUN;
                        shadow_val_reg   <= display_val;
                        shadow_dp_reg    <= dp_in;
                        shadow_blank_reg <= blank;
                        anode            <= ~(8'd1 << sel_index);
                        segments         <= digit_seg[sel_index];
                        dp               <= digit_dp[sel_index];
                    end else begin
                        anode    <= 8'hFF;
                        segments <= 7'h7F;
                        dp       <= 1'b1;
                    end
                end
                RUN: begin
                    if (!display_en) begin
                        state_reg <= OFF;
                        timer_reg <= '0;
                        index_reg <= '0;
                        anode     <= 8'hFF;
                        segments  <= 7'h7F;
                        dp        <= 1'b1;
                    end else if (timer_last) begin
                        timer_reg <= '0;
                        index_reg <= sel_index;
                        anode     <= ~(8'd1 << sel_index);
                        segments  <= digit_seg[sel_index];
                        dp        <= digit_dp[sel_index];
                        if (frame_wrap) begin
                            frame_done       <= 1'b1;
                            shadow_val_reg   <= display_val;
                            shadow_dp_reg    <= dp_in;
                            shadow_blank_reg <= blank;
                        end
                    end else begin
                        timer_reg <= timer_reg + TIMER_W'(1);
                    end
                end
                default: state_reg <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Scoreboard bench for seven_segment_mux: expected digit records are queued as
// stimulus is applied and compared cycle by cycle against the scanned outputs.
module tb_seven_segment_mux;

    localparam int SC = 100;

    logic        clk;
    logic        rst;
    logic        display_en;
    logic [31:0] display_val;
    logic [7:0]  dp_in;
    logic [7:0]  blank;
    logic [6:0]  segments;
    logic        dp;
    logic [7:0]  anode;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } rec_t;

    rec_t exp_q[$];

    logic [6:0] dec_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seven_segment_mux #(
        .CLK_FREQUENCY          (100_000_000),
        .MIN_SEGMENT_DISPLAY_US (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .display_en  (display_en),
        .display_val (display_val),
        .dp_in       (dp_in),
        .blank       (blank),
        .segments    (segments),
        .dp          (dp),
        .anode       (anode),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_frame(input logic [31:0] val, input logic [7:0] dpv, input logic [7:0] blk);
        rec_t r;
        logic [3:0] nib;
        for (int d = 0; d < 8; d++) begin
            nib   = val[4*d +: 4];
            r.an  = ~(8'd1 << d);
            r.seg = blk[d] ? 7'h7F : dec_tab[nib];
            r.dp  = blk[d] ? 1'b1 : ~dpv[d];
            exp_q.push_back(r);
        end
    endtask

    // Samples stop_at cycles of one frame on negedges; optionally changes
    // display_val right after sample chg_cycle.
    task automatic run_frame(input string name, input bit fd_first, input int stop_at,
                             input int chg_cycle, input logic [31:0] chg_val);
        rec_t cur [8];
        logic exp_fd;
        int d;
        for (int i = 0; i < 8; i++) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard empty: got 0 records, need 8", name);
                cur[i] = '0;
            end else begin
                cur[i] = exp_q.pop_front();
            end
        end
        for (int k = 0; k < stop_at; k++) begin
            @(negedge clk);
            d = k / SC;
            exp_fd = fd_first && (k == 0);
            checks++;
            if ({anode, segments, dp, frame_done} !== {cur[d], exp_fd}) begin
                errors++;
                $display("FAIL %s cycle %0d digit %0d: anode=%h seg=%b dp=%b fd=%b, need anode=%h seg=%b dp=%b fd=%b",
                         name, k, d, anode, segments, dp, frame_done,
                         cur[d].an, cur[d].seg, cur[d].dp, exp_fd);
            end
            checks++;
            if ($countones(~anode) > 1) begin
                errors++;
                $display("FAIL %s one-hot cycle %0d: anode=%h, need at most one low bit", name, k, anode);
            end
            if (k == chg_cycle) display_val = chg_val;
        end
    endtask

    task automatic check_off(input string name, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            checks++;
            if ({anode, segments, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL %s cycle %0d: anode=%h seg=%b dp=%b fd=%b, need FF 1111111 1 0",
                         name, k, anode, segments, dp, frame_done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; display_en = 1'b0; display_val = '0; dp_in = '0; blank = '0;
        check_off("reset_hold", 3);
        rst = 1'b0;
        check_off("idle_off", 5);
        $display("test_reset done");
    endtask

    task automatic test_timing();
        display_val = 32'h89ABCDEF;
        display_en  = 1'b1;
        push_frame(display_val, dp_in, blank);
        run_frame("timing_f0", 1'b0, 8*SC, -1, '0);
        push_frame(display_val, dp_in, blank);
        run_frame("timing_f1", 1'b1, 8*SC, -1, '0);
        $display("test_timing done");
    endtask

    task automatic test_tearing();
        display_val = 32'h01234567;
        push_frame(display_val, dp_in, blank);
        run_frame("tear_old", 1'b1, 8*SC, 350, 32'hFFFFFFFF);
        push_frame(32'hFFFFFFFF, dp_in, blank);
        run_frame("tear_new", 1'b1, 8*SC, -1, '0);
        $display("test_tearing done");
    endtask

    task automatic test_blank_dp();
        display_val = 32'h76543210;
        blank = 8'h0F;
        dp_in = 8'h10;
        push_frame(display_val, dp_in, blank);
        run_frame("blank_dp", 1'b1, 8*SC, -1, '0);
        blank = '0;
        dp_in = '0;
        $display("test_blank_dp done");
    endtask

    task automatic test_enable_toggle();
        display_val = 32'h13579BDF;
        push_frame(display_val, dp_in, blank);
        run_frame("en_partial", 1'b1, 3*SC + 50, -1, '0);
        display_en = 1'b0;
        check_off("en_disabled", 50);
        display_val = 32'hC0FFEE42;
        dp_in       = 8'h01;
        display_en  = 1'b1;
        push_frame(display_val, dp_in, blank);
        run_frame("en_restart", 1'b0, 8*SC, -1, '0);
        dp_in = '0;
        $display("test_enable_toggle done");
    endtask

    task automatic test_async_reset();
        display_val = 32'h2468ACE1;
        push_frame(display_val, dp_in, blank);
        run_frame("ar_partial", 1'b1, 5*SC + 40, -1, '0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({anode, segments, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_immediate: anode=%h seg=%b dp=%b fd=%b, need FF 1111111 1 0",
                     anode, segments, dp, frame_done);
        end
        check_off("ar_held", 3);
        rst = 1'b0;
        push_frame(display_val, dp_in, blank);
        run_frame("ar_f0", 1'b0, 8*SC, -1, '0);
        push_frame(display_val, dp_in, blank);
        run_frame("ar_f1", 1'b1, 8*SC, -1, '0);
        $display("test_async_reset done");
    endtask

    task automatic test_decode_sweep();
        for (int v = 0; v < 16; v++) begin
            display_val = {28'h9876543, 4'(v)};
            push_frame(display_val, dp_in, blank);
            run_frame($sformatf("sweep_%0h", v), 1'b1, 8*SC, -1, '0);
        end
        $display("test_decode_sweep done");
    endtask

    initial begin
        test_reset();
        test_timing();
        test_tearing();
        test_blank_dp();
        test_enable_toggle();
        test_async_reset();
        test_decode_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
